// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while clr is low; tick marks the last count.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned     CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = !clr && (cnt_q == LAST);
  // One cycle ahead of tick, so registered strobes can land in the final cycle of a bit.
  assign pre_tick = !clr && (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the registered-read FIFO and sends each as a UART frame (start, 8 data LSB first, optional even parity, stop).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned        IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]   LAST_BIT = IDX_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               tx_q, tx_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               baud_clr;
  logic               baud_tick;
  logic               baud_pre_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .tick     (baud_tick),
    .pre_tick (baud_pre_tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = tx_q;
    fifo_rd_d    = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    baud_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d     = IDLE_LEVEL;
        busy_d   = 1'b0;
        baud_clr = 1'b1;
        if (en && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = POP;
        end
      end

      POP: begin
        baud_clr = 1'b1;
        state_d  = LOAD;
      end

      // fifo_data is valid here, one cycle after the pop strobe.
      LOAD: begin
        baud_clr  = 1'b1;
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_idx_d = '0;
        tx_d      = 1'b0;
        state_d   = START;
      end

      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = IDLE_LEVEL;
              state_d = STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = STOP;
        end
      end

      STOP: begin
        frame_done_d = baud_pre_tick;
        if (baud_tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        tx_d     = IDLE_LEVEL;
        busy_d   = 1'b0;
        baud_clr = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_idx_q    <= '0;
      tx_q         <= IDLE_LEVEL;
      fifo_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      fifo_rd_q    <= fifo_rd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_rd    = fifo_rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized checks of fifo_uart_tx against a frame-level line model and a queue-based FIFO.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       tx0, rd0, busy0, fd0;
  logic       tx1, rd1, busy1, fd1;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic [7:0] wd0 = '0, wd1 = '0;
  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         rd_cnt0 = 0, rd_cnt1 = 0;
  int         n_cmp = 0, n_bad = 0;
  int         sel = 0;
  logic       obs_tx, obs_rd, obs_busy, obs_fd;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst_n), .en(en), .fifo_empty(empty0), .fifo_data(dout0),
    .fifo_rd(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst_n), .en(en), .fifo_empty(empty1), .fifo_data(dout1),
    .fifo_rd(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  // Registered-read FIFO models: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (wr0) q0.push_back(wd0);
    if (rd0 && q0.size() != 0) dout0 <= q0.pop_front();
    empty0 <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (wr1) q1.push_back(wd1);
    if (rd1 && q1.size() != 0) dout1 <= q1.pop_front();
    empty1 <= (q1.size() == 0);
  end

  always @(negedge clk) begin
    if (rd0 === 1'b1) rd_cnt0++;
    if (rd1 === 1'b1) rd_cnt1++;
  end

  always_comb begin
    obs_tx   = (sel == 0) ? tx0   : tx1;
    obs_rd   = (sel == 0) ? rd0   : rd1;
    obs_busy = (sel == 0) ? busy0 : busy1;
    obs_fd   = (sel == 0) ? fd0   : fd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level for bit slot k of a frame: 0 start, 1..8 data LSB first, 9 even parity if enabled, else stop.
  function automatic logic frame_bit(input logic [7:0] b, input int pe, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe != 0 && k == 9) return (($countones(b) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic push(input int s, input logic [7:0] b);
    if (s == 0) begin wr0 = 1'b1; wd0 = b; end
    else        begin wr1 = 1'b1; wd1 = b; end
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input int pe, input int drop_at, output int w);
    int nb;
    bit found;
    nb    = (10 + pe) * CPB;
    found = 1'b0;
    w     = 0;
    while (!found && w < 200) begin
      @(negedge clk);
      w++;
      if (obs_rd === 1'b1) found = 1'b1;
      else begin
        check("idle_tx", obs_tx, 1);
        check("idle_busy", obs_busy, 0);
      end
    end
    check("pop_seen", found, 1);
    if (!found) return;
    @(negedge clk);
    check("rd_single", obs_rd, 0);
    check("load_tx", obs_tx, 1);
    check("load_busy", obs_busy, 1);
    for (int c = 0; c < nb; c++) begin
      @(negedge clk);
      if (c == drop_at) en = 1'b0;
      check("frame_tx", obs_tx, frame_bit(b, pe, c / int'(CPB)));
      check("frame_done", obs_fd, (c == nb - 1));
      check("frame_busy", obs_busy, 1);
    end
  endtask

  initial begin
    int w, base, n;
    bit found;
    logic [7:0] r1, r2;
    logic [7:0] bytes[$];

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx0", tx0, 1);
    check("rst_rd0", rd0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_fd0", fd0, 0);
    check("rst_tx1", tx1, 1);
    check("rst_busy1", busy1, 0);

    // Empty FIFO with en high: line stays idle.
    en    = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("empty_tx0", tx0, 1);
      check("empty_busy0", busy0, 0);
      check("empty_tx1", tx1, 1);
    end
    check("empty_rd0", rd_cnt0, 0);
    check("empty_rd1", rd_cnt1, 0);

    // 0xA5, no parity.
    sel = 0; en = 1'b0;
    push(0, 8'hA5);
    en = 1'b1;
    check_frame(8'hA5, 0, -1, w);
    @(negedge clk);
    check("a5_busy_end", busy0, 0);
    check("a5_rd_count", rd_cnt0, 1);
    check("a5_empty", empty0, 1);

    // 0x07 with even parity, 44-cycle frame.
    sel = 1; en = 1'b0;
    push(1, 8'h07);
    en = 1'b1;
    check_frame(8'h07, 1, -1, w);
    @(negedge clk);
    check("p07_busy_end", busy1, 0);
    check("p07_rd_count", rd_cnt1, 1);
    check("p07_empty", empty1, 1);

    // Back-to-back 0x55, 0x0F.
    sel = 0; en = 1'b0;
    push(0, 8'h55);
    push(0, 8'h0F);
    base = rd_cnt0;
    en = 1'b1;
    check_frame(8'h55, 0, -1, w);
    check_frame(8'h0F, 0, -1, w);
    check("b2b_gap", w, 2);
    @(negedge clk);
    check("b2b_rd_count", rd_cnt0 - base, 2);
    check("b2b_empty", empty0, 1);

    // Reset during data bit 3: popped byte lost, next byte sent whole.
    en = 1'b0;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    push(0, r1);
    push(0, r2);
    base  = rd_cnt0;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (rd0 === 1'b1) found = 1'b1;
    end
    check("rst_mid_pop", found, 1);
    @(negedge clk);
    repeat (18) @(negedge clk);
    check("rst_mid_bit3", tx0, r1[3]);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx0, 1);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_rd", rd0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_frame(r2, 0, -1, w);
    @(negedge clk);
    check("rst_mid_busy_end", busy0, 0);
    check("rst_mid_rd_count", rd_cnt0 - base, 2);
    check("rst_mid_empty", empty0, 1);

    // en dropped during the start bit of 0x3C with another byte queued.
    en = 1'b0;
    r2 = 8'($urandom);
    push(0, 8'h3C);
    push(0, r2);
    base = rd_cnt0;
    en = 1'b1;
    check_frame(8'h3C, 0, 1, w);
    repeat (20) @(negedge clk);
    check("en_drop_rd_count", rd_cnt0 - base, 1);
    check("en_drop_not_empty", empty0, 0);
    check("en_drop_tx", tx0, 1);
    check("en_drop_busy", busy0, 0);
    en = 1'b1;
    check_frame(r2, 0, -1, w);
    @(negedge clk);
    check("en_resume_rd_count", rd_cnt0 - base, 2);
    check("en_resume_empty", empty0, 1);

    // Random back-to-back bursts on both configurations.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      en  = 1'b0;
      n   = int'($urandom_range(3, 5));
      bytes.delete();
      for (int i = 0; i < n; i++) begin
        bytes.push_back(8'($urandom));
        push(s, bytes[i]);
      end
      base = (s == 0) ? rd_cnt0 : rd_cnt1;
      en = 1'b1;
      for (int i = 0; i < n; i++) begin
        check_frame(bytes[i], s, -1, w);
        if (i > 0) check("rand_gap", w, 2);
      end
      @(negedge clk);
      check("rand_rd_count", ((s == 0) ? rd_cnt0 : rd_cnt1) - base, n);
      check("rand_empty", (s == 0) ? empty0 : empty1, 1);
      check("rand_busy_end", obs_busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
